// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port constants for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // One-hot grant vector for a port index
    function automatic logic [1:0] port_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational 2-way picker, round-robin or fixed priority (MEM_ARB_FIXED_PRIO_EN)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = i_last;

    // Load/store port always wins a tie
    always_comb begin
        o_gnt = i_req1 ? port_onehot(PORT_DATA) : (i_req0 ? port_onehot(PORT_FETCH) : 2'b00);
    end
`else
    // On a tie the port that was not granted last wins; a lone requester always wins
    always_comb begin
        o_gnt = (i_req0 && i_req1) ? port_onehot(i_last == PORT_FETCH ? PORT_DATA : PORT_FETCH)
                                   : {i_req1, i_req0};
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/gnt arbiter and IDLE/ISSUE/RESP sequencer for a single-port memory; MEM_ARB_FIXED_PRIO_EN selects fixed priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            r_state;
    state_t            w_next;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [1:0]        w_pick;
    logic              w_take;
    logic              w_last;
    logic              w_rd_resp;

    mem_arb_pick u_pick (
        .i_req0 (req0),
        .i_req1 (req1),
        .i_last (w_last),
        .o_gnt  (w_pick)
    );

    assign w_take    = (r_state == IDLE) && (|w_pick);
    assign w_rd_resp = (r_state == RESP) && !r_we;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_last = PORT_DATA;
`else
    logic r_last;

    // Remember the last granted port; reset value lets port 0 win the first tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_last <= PORT_DATA;
        else if (w_take)
            r_last <= w_pick[1];
    end

    assign w_last = r_last;
`endif

    // State register; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state and all handshake/strobe outputs, decoded from the state register
    always_comb begin
        w_next    = r_state == IDLE ? (w_take ? ISSUE : IDLE) : (r_state == ISSUE ? RESP : IDLE);
        gnt0      = (r_state == IDLE) && w_pick[0];
        gnt1      = (r_state == IDLE) && w_pick[1];
        ack0      = (r_state == RESP) && (r_port == PORT_FETCH);
        ack1      = (r_state == RESP) && (r_port == PORT_DATA);
        busy      = r_state != IDLE;
        mem_read  = (r_state == ISSUE) && !r_we;
        mem_write = (r_state == ISSUE) && r_we;
        mem_addr  = r_addr;
        mem_din   = r_wdata;
        rdata0    = (w_rd_resp && r_port == PORT_FETCH) ? mem_dout : r_rdata0;
        rdata1    = (w_rd_resp && r_port == PORT_DATA) ? mem_dout : r_rdata1;
    end

    // Capture the winner's payload at the grant edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_port  <= PORT_FETCH;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_port  <= w_pick[1];
            r_we    <= w_pick[1] ? we1 : we0;
            r_addr  <= w_pick[1] ? addr1 : addr0;
            r_wdata <= w_pick[1] ? wdata1 : wdata0;
        end
    end

    // Hold the last read result per port; writes leave it untouched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_rd_resp) begin
            if (r_port == PORT_FETCH)
                r_rdata0 <= mem_dout;
            else
                r_rdata1 <= mem_dout;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a registered-read memory model
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_din;
    logic [8:0]  mem_addr;
    logic [31:0] mem_dout = '0;

    bit [31:0]   mem [512];
    bit          wr  [512];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_hold [2];
    exp_t        m_e;
    logic [31:0] m_d, m_o;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // Power-on contents of the memory model
    function automatic logic [31:0] init_val(input logic [8:0] a);
        return (a == 9'h010) ? 32'hDEADBEEF : (32'hA500_0000 | {23'd0, a});
    endfunction

    // Single-port memory with registered read data
    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_din;
            wr[mem_addr]  <= 1'b1;
        end
        if (mem_read)
            mem_dout <= wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

    // Queue the ack a granted access must produce; writes must show the unchanged hold value
    function automatic void expect_ack(input bit p, input bit w, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = w ? exp_hold[p] : d;
        if (!w)
            exp_hold[p] = d;
        sb.push_back(e);
    endfunction

    // Scoreboard: every ack is popped and compared, including the idle port's rdata
    always @(negedge clock) begin
        if (reset_n && (ack0 || ack1)) begin
            checks++;
            if (ack0 && ack1) begin
                errors++;
                $display("FAIL ack_both ack0=%0b ack1=%0b required one-hot", ack0, ack1);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected ack0=%0b ack1=%0b required no ack", ack0, ack1);
            end else begin
                m_e = sb.pop_front();
                m_d = ack1 ? rdata1 : rdata0;
                m_o = ack1 ? rdata0 : rdata1;
                if (ack1 !== m_e.port || m_d !== m_e.data || m_o !== exp_hold[!m_e.port]) begin
                    errors++;
                    $display("FAIL ack_data port=%0d rdata=%h other=%h required port=%0d rdata=%h other=%h",
                             ack1, m_d, m_o, m_e.port, m_e.data, exp_hold[!m_e.port]);
                end
            end
        end
    end

    // Present one request, wait for its grant, optionally queue its ack, then drop req
    task automatic issue(input bit p, input bit w, input logic [8:0] a, input logic [31:0] d, input bit exp);
        bit got;
        @(posedge clock); #1;
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            got = p ? gnt1 : gnt0;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt_timeout port=%0d no gnt seen, required gnt within 10 cycles", p);
        end else if (exp)
            expect_ack(p, w, d);
        @(posedge clock); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        exp_hold[0] = '0;
        exp_hold[1] = '0;
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=0000000",
                     {gnt0, gnt1, ack0, ack1, busy, mem_read, mem_write});
        end
        checks++;
        if ({mem_addr, mem_din, rdata0, rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h din=%h rd0=%h rd1=%h required all 0",
                     mem_addr, mem_din, rdata0, rdata1);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        issue(1'b0, 1'b0, 9'h010, 32'hDEADBEEF, 1'b1);
        @(negedge clock);
        checks++;
        if ({mem_read, mem_write, mem_addr, busy} !== {1'b1, 1'b0, 9'h010, 1'b1}) begin
            errors++;
            $display("FAIL read_issue rd=%0b wr=%0b addr=%h busy=%0b required 1 0 010 1",
                     mem_read, mem_write, mem_addr, busy);
        end
        @(negedge clock);
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_ack ack0=%0b rdata0=%h required 1 deadbeef", ack0, rdata0);
        end
        @(negedge clock);
        checks++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold ack0=%0b busy=%0b rdata0=%h required 0 0 deadbeef", ack0, busy, rdata0);
        end
    endtask

    task automatic test_write_read();
        issue(1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b1);
        @(negedge clock);
        checks++;
        if ({mem_write, mem_read, mem_addr, mem_din} !== {1'b1, 1'b0, 9'h1FF, 32'h12345678}) begin
            errors++;
            $display("FAIL write_issue wr=%0b rd=%0b addr=%h din=%h required 1 0 1ff 12345678",
                     mem_write, mem_read, mem_addr, mem_din);
        end
        @(negedge clock);
        checks++;
        if (ack1 !== 1'b1 || mem_write !== 1'b0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL write_ack ack1=%0b wr=%0b rdata1=%h required 1 0 00000000", ack1, mem_write, rdata1);
        end
        issue(1'b1, 1'b0, 9'h1FF, 32'h12345678, 1'b1);
        repeat (2) @(negedge clock);
        checks++;
        if (ack1 !== 1'b1 || rdata1 !== 32'h12345678) begin
            errors++;
            $display("FAIL readback ack1=%0b rdata1=%h required 1 12345678", ack1, rdata1);
        end
    endtask

    task automatic test_contention();
        int  last;
        int  n;
        bit  p;
        bit  ep;
        @(posedge clock); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h030;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h031;
        last = -3;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (gnt0 || gnt1) begin
                p = gnt1;
`ifdef MEM_ARB_FIXED_PRIO_EN
                ep = 1'b1;
`else
                ep = n[0];
`endif
                checks++;
                if (p !== ep || (gnt0 && gnt1) || c - last != 3) begin
                    errors++;
                    $display("FAIL contention_gnt n=%0d gnt0=%0b gnt1=%0b gap=%0d required port=%0d gap=3",
                             n, gnt0, gnt1, c - last, ep);
                end
                expect_ack(p, 1'b0, init_val(p ? 9'h031 : 9'h030));
                last = c;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_count grants=%0d required 4", n);
        end
        @(posedge clock); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        bit got;
        int cnt;
        @(posedge clock); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h040;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clock);
            got = gnt0;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_first no gnt0 seen, required gnt0 within 5 cycles");
        end
        expect_ack(1'b0, 1'b0, init_val(9'h040));
        @(posedge clock); #1;
        addr0 = 9'h041;
        got = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge clock);
            if (gnt0) begin
                got = 1'b1;
                cnt = i;
            end
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL b2b_spacing gap=%0d required 3", cnt);
        end
        if (got)
            expect_ack(1'b0, 1'b0, init_val(9'h041));
        @(posedge clock); #1;
        req0 = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid_write();
        issue(1'b0, 1'b1, 9'h020, 32'hAAAAAAAA, 1'b0);
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre wr=%0b required 1", mem_write);
        end
        reset_n = 1'b0;
        exp_hold[0] = '0;
        exp_hold[1] = '0;
        #1;
        checks++;
        if ({mem_write, mem_read, busy, ack0, ack1} !== 5'b0) begin
            errors++;
            $display("FAIL abort_drop got=%b required 00000", {mem_write, mem_read, busy, ack0, ack1});
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        issue(1'b0, 1'b0, 9'h020, init_val(9'h020), 1'b1);
        repeat (3) @(negedge clock);
        checks++;
        if (rdata0 !== init_val(9'h020)) begin
            errors++;
            $display("FAIL abort_old rdata0=%h required %h", rdata0, init_val(9'h020));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_write();
        repeat (4) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_acks left=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
